// File: rtl/gene_line_packer.sv
// Streaming 2-bit nucleotide packer: ASCII bases in, 2*BASES-bit MSB-first lines out.
// Optional strict checking of characters enabled by defining GENE_PACK_STRICT_EN.
module gene_line_packer #(
  parameter int BASES = 100,
  parameter int CNT_W = 7
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [7:0]           InChar,
  input  logic                 InValid,
  input  logic                 InLast,
  output logic                 InReady,
  output logic [2*BASES-1:0]   Line,
  output logic [CNT_W-1:0]     LineCount,
  output logic                 LineErr,
  output logic                 LineValid,
  input  logic                 LineReady
);

  localparam int LW = 2 * BASES;

  typedef enum logic {FILL, HOLD} state_e;

  state_e             state_q;
  logic [LW-1:0]      acc_q, acc_d, line_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc, count_q;
  logic               valid_q;
  logic [1:0]         code;
  logic               accept, closing, out_free, load_fill, load_hold;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    code = 2'b00;
    case (InChar)
      8'h43, 8'h63: code = 2'b01;  // C c
      8'h47, 8'h67: code = 2'b10;  // G g
      8'h54, 8'h74: code = 2'b11;  // T t
      default:      code = 2'b00;  // A a and anything else
    endcase
  end

  // Accumulator with the incoming base dropped into the slot selected by the counter.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < BASES; i++) begin
      if (cnt_q == CNT_W'(i)) acc_d[LW-2-2*i +: 2] = code;
    end
  end

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign closing   = InLast || (cnt_q == CNT_W'(BASES - 1));
  assign InReady   = (state_q == FILL);
  assign accept    = InValid && InReady;
  assign out_free  = !valid_q || LineReady;
  assign load_fill = accept && closing && out_free;
  assign load_hold = (state_q == HOLD) && out_free;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else if (load_fill) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      line_q  <= acc_d;
      count_q <= cnt_inc;
      valid_q <= 1'b1;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (load_hold) begin
      line_q  <= acc_q;
      count_q <= cnt_q;
      valid_q <= 1'b1;
      acc_q   <= '0;
      cnt_q   <= '0;
      state_q <= FILL;
    end else begin
      if (LineReady) valid_q <= 1'b0;
      if (accept) begin
        acc_q <= acc_d;
        cnt_q <= cnt_inc;
        // Closing here means the output is occupied; cnt_q then holds the line's base count.
        if (closing) state_q <= HOLD;
      end
    end
  end

  assign Line      = line_q;
  assign LineCount = count_q;
  assign LineValid = valid_q;

`ifdef GENE_PACK_STRICT_EN
  logic err_q, err_d, lerr_q, bad_char;

  assign bad_char = !(InChar inside {8'h41, 8'h43, 8'h47, 8'h54, 8'h61, 8'h63, 8'h67, 8'h74});
  assign err_d    = err_q || (accept && bad_char);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_q  <= 1'b0;
      lerr_q <= 1'b0;
    end else if (load_fill) begin
      lerr_q <= err_d;
      err_q  <= 1'b0;
    end else if (load_hold) begin
      lerr_q <= err_q;
      err_q  <= 1'b0;
    end else begin
      err_q  <= err_d;
    end
  end

  assign LineErr = lerr_q;
`else
  assign LineErr = 1'b0;
`endif

endmodule

// File: tb/tb_gene_line_packer.sv
// Self-checking bench for gene_line_packer: directed test-plan sequences plus random traffic
// against a queue-based line model.
module tb_gene_line_packer;

  localparam int BASES = 100;
  localparam int CNT_W = 7;
  localparam int LW    = 2 * BASES;

  typedef struct {
    logic [LW-1:0] line;
    int            cnt;
    bit            err;
  } line_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       in_char = 8'h0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [LW-1:0]    line;
  logic [CNT_W-1:0] line_count;
  logic             line_err;
  logic             line_valid;
  logic             line_ready = 1'b0;

  int    n_checks = 0;
  int    n_fail   = 0;
  byte   cur[$];
  line_t exp_q[$];
  bit    last_acc;

  always #5 clk = ~clk;

  gene_line_packer #(.BASES(BASES), .CNT_W(CNT_W)) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .InChar    (in_char),
    .InValid   (in_valid),
    .InLast    (in_last),
    .InReady   (in_ready),
    .Line      (line),
    .LineCount (line_count),
    .LineErr   (line_err),
    .LineValid (line_valid),
    .LineReady (line_ready)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input byte c);
    case (c)
      "C", "c": return 2'b01;
      "G", "g": return 2'b10;
      "T", "t": return 2'b11;
      default:  return 2'b00;
    endcase
  endfunction

  function automatic bit is_bad(input byte c);
`ifdef GENE_PACK_STRICT_EN
    return !(c inside {"A", "C", "G", "T", "a", "c", "g", "t"});
`else
    return 1'b0;
`endif
  endfunction

  // Reference: append 2-bit codes in arrival order, then left-justify into the line.
  task automatic close_line();
    line_t l;
    l.line = '0;
    l.err  = 1'b0;
    l.cnt  = cur.size();
    foreach (cur[i]) begin
      l.line = (l.line << 2) | LW'(enc(cur[i]));
      l.err  = l.err | is_bad(cur[i]);
    end
    l.line = l.line << (2 * (BASES - l.cnt));
    exp_q.push_back(l);
    cur.delete();
  endtask

  task automatic cycle(input bit v, input byte ch, input bit last, input bit rdy);
    bit    m_ready, fire, acc;
    line_t tmp;
    @(negedge clk);
    in_valid   = v;
    in_char    = ch;
    in_last    = last;
    line_ready = rdy;
    #1;
    m_ready = (exp_q.size() < 2);
    check("in_ready", in_ready, m_ready);
    check("line_valid", line_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("line", line, exp_q[0].line);
      check("line_count", line_count, exp_q[0].cnt);
      check("line_err", line_err, exp_q[0].err);
    end
    fire = (exp_q.size() > 0) && rdy;
    acc  = v && m_ready;
    @(posedge clk);
    if (fire) tmp = exp_q.pop_front();
    if (acc) begin
      cur.push_back(ch);
      if (last || cur.size() == BASES) close_line();
    end
    last_acc = acc;
  endtask

  task automatic offer(input byte ch, input bit last, input bit rdy);
    int tries = 0;
    last_acc = 1'b0;
    while (!last_acc && tries < 500) begin
      cycle(1'b1, ch, last, rdy);
      tries++;
    end
    check("offer_accepted", last_acc, 1'b1);
  endtask

  task automatic send_str(input string s, input bit last_end, input bit rdy);
    for (int i = 0; i < s.len(); i++) offer(s[i], last_end && (i == s.len() - 1), rdy);
  endtask

  task automatic send_rep(input byte ch, input int n, input bit rdy);
    for (int i = 0; i < n; i++) offer(ch, 1'b0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rdy);
  endtask

  // Reset mid-cycle, check outputs clear without waiting for a clock edge.
  task automatic async_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_line", line, '0);
    check("rst_line_count", line_count, '0);
    check("rst_line_err", line_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    cur.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string acgt;
    byte   pool[11];
    bit    rdy_bias;
    pool = '{"A", "C", "G", "T", "a", "c", "g", "t", "N", "x", "-"};

    #3;
    check("init_line_valid", line_valid, 1'b0);
    check("init_line", line, '0);
    check("init_line_count", line_count, '0);
    check("init_line_err", line_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // 100 x 'A' with consumer ready: single all-zero full line
    send_rep("A", 100, 1'b1);
    idle(3, 1'b1);

    // "ACGT" x 25 then 100 x 't', back to back
    acgt = "";
    for (int i = 0; i < 25; i++) acgt = {acgt, "ACGT"};
    send_str(acgt, 1'b0, 1'b1);
    send_rep("t", 100, 1'b1);
    idle(3, 1'b1);

    // Short record closed by InLast, then a following line starting at slot 0
    send_str("GAT", 1'b1, 1'b1);
    send_str("CG", 1'b1, 1'b1);
    idle(3, 1'b1);

    // InLast without InValid is ignored
    cycle(1'b0, "C", 1'b1, 1'b1);
    send_str("GG", 1'b1, 1'b1);
    idle(2, 1'b1);

    // Backpressure: 200 accepted, stall, then release and send the remaining 50
    send_rep("G", 100, 1'b0);
    send_rep("c", 100, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, "A", 1'b0, 1'b0);
    send_rep("T", 50, 1'b1);
    send_str("A", 1'b1, 1'b1);
    idle(4, 1'b1);

    // Invalid character inside a short record, then a clean full line
    send_str("ANC", 1'b1, 1'b1);
    send_rep("C", 100, 1'b1);
    idle(3, 1'b1);

    // Reset after 40 characters, then a fresh line
    send_rep("G", 40, 1'b1);
    async_reset();
    send_rep("T", 100, 1'b1);
    idle(3, 1'b1);

    // Reset while in HOLD, then a fresh line
    send_rep("C", 200, 1'b0);
    cycle(1'b1, "A", 1'b0, 1'b0);
    async_reset();
    send_rep("g", 100, 1'b1);
    idle(3, 1'b1);

    // Random traffic with varying consumer pressure
    for (int blk = 0; blk < 15; blk++) begin
      rdy_bias = blk[0];
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 3) != 0,
              pool[$urandom_range(0, 10)],
              $urandom_range(0, 40) == 0,
              rdy_bias ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0));
      end
    end
    idle(6, 1'b1);
    check("drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
